// File: rtl/float_add_pipe.sv
// rtl/float_add_pipe.sv - three-stage pipelined floating-point adder/subtractor
//
// Purpose: adds (or subtracts) two IEEE-style floats with flush-to-zero input
// handling, truncation rounding and NaN/infinity special cases. A sideband
// tag travels with each transaction. Valid/ready handshake on both sides with
// per-stage load enables so bubbles collapse and stalls hold the output.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    operand handshake
//   lhs, rhs, op_sub       operands; op_sub=1 computes lhs-rhs
//   in_tag                 sideband tag carried to out_tag
//   out_valid / out_ready  result handshake
//   res, out_tag           result and its tag
//   flag_nan/inf/ovf       res is NaN / res is infinity / finite overflow
module float_add_pipe #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int TAG_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [EXP_WIDTH+MAN_WIDTH:0] lhs,
  input  logic [EXP_WIDTH+MAN_WIDTH:0] rhs,
  input  logic                         op_sub,
  input  logic [TAG_WIDTH-1:0]         in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0] res,
  output logic [TAG_WIDTH-1:0]         out_tag,
  output logic                         flag_nan,
  output logic                         flag_inf,
  output logic                         flag_ovf
);

  localparam int FLOAT_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int MW  = MAN_WIDTH + 3;            // sign + carry + hidden + mantissa
  localparam int XW  = EXP_WIDTH + 2;            // exponent with headroom and sign
  localparam int LZW = $clog2(MAN_WIDTH + 1);

  // Stage valids and load enables; S3 is the output register.
  logic v1_q, v2_q, v3_q;
  logic ld1, ld2, ld3;

  assign ld3      = !v3_q || out_ready;
  assign ld2      = !v2_q || ld3;
  assign ld1      = !v1_q || ld2;
  assign in_ready = ld1 && !rst;

  // ---------------- S1: swap, unpack, align ----------------
  logic                 l_sgn, r_sgn, b_sgn, s_sgn, swap;
  logic [EXP_WIDTH-1:0] l_exp, r_exp, b_exp, s_exp, e_diff;
  logic [MAN_WIDTH-1:0] l_man, r_man, b_man, s_man;
  logic                 l_nan, r_nan, l_inf, r_inf;
  logic [MW-1:0]        b_mag, s_mag, b_sm, s_sm, s_al;
  logic                 nan1_d, inf1_d;

  assign {l_sgn, l_exp, l_man} = lhs;
  assign r_sgn = rhs[FLOAT_WIDTH-1] ^ op_sub;    // subtraction = flipped rhs sign
  assign r_exp = rhs[FLOAT_WIDTH-2 -: EXP_WIDTH];
  assign r_man = rhs[MAN_WIDTH-1:0];

  always_comb begin
    // Strict compare keeps the original order on equal magnitude.
    swap = {r_exp, r_man} > {l_exp, l_man};
    {b_sgn, b_exp, b_man} = swap ? {r_sgn, r_exp, r_man} : {l_sgn, l_exp, l_man};
    {s_sgn, s_exp, s_man} = swap ? {l_sgn, l_exp, l_man} : {r_sgn, r_exp, r_man};

    l_nan = (&l_exp) && (|l_man);
    r_nan = (&r_exp) && (|r_man);
    l_inf = (&l_exp) && !(|l_man);
    r_inf = (&r_exp) && !(|r_man);
    nan1_d = l_nan || r_nan || (l_inf && r_inf && (l_sgn != r_sgn));
    // An infinite operand always wins the swap, so b_sgn is its sign.
    inf1_d = (l_inf || r_inf) && !nan1_d;

    // Zero exponent flushes the operand to zero.
    b_mag = (b_exp == '0) ? '0 : {3'b001, b_man};
    s_mag = (s_exp == '0) ? '0 : {3'b001, s_man};
    b_sm  = b_sgn ? -b_mag : b_mag;
    s_sm  = s_sgn ? -s_mag : s_mag;

    e_diff = b_exp - s_exp;
    if (int'(e_diff) >= MW) s_al = '0;
    else                    s_al = $unsigned($signed(s_sm) >>> e_diff);
  end

  logic [MW-1:0]        a1_q, b1_q;
  logic [EXP_WIDTH-1:0] e1_q;
  logic                 nan1_q, inf1_q, isgn1_q;
  logic [TAG_WIDTH-1:0] tag1_q;

  // ---------------- S2: signed mantissa add ----------------
  // Two aligned operands of magnitude < 2^(MAN_WIDTH+1) cannot overflow MW bits.
  logic [MW-1:0]        sum2_q;
  logic [EXP_WIDTH-1:0] e2_q;
  logic                 nan2_q, inf2_q, isgn2_q;
  logic [TAG_WIDTH-1:0] tag2_q;

  // ---------------- S3: normalise, pack, special select ----------------
  logic                   sgn3, carry, is_zero, is_ovf;
  logic [MW-2:0]          mag3;
  logic [LZW-1:0]         lz;
  logic [MAN_WIDTH:0]     shl;
  logic [MAN_WIDTH-1:0]   man_n;
  logic [XW-1:0]          exp_n;
  logic [FLOAT_WIDTH-1:0] res_d;
  logic                   nan_d, inf_d, ovf_d;

  always_comb begin
    sgn3  = sum2_q[MW-1];
    mag3  = sgn3 ? (~sum2_q[MW-2:0] + 1'b1) : sum2_q[MW-2:0];
    carry = mag3[MW-2];

    // Highest set bit wins because the loop runs upward.
    lz = '0;
    for (int i = 0; i <= MAN_WIDTH; i++) begin
      if (mag3[i]) lz = LZW'(MAN_WIDTH - i);
    end
    shl = mag3[MAN_WIDTH:0] << lz;

    if (carry) begin
      man_n = mag3[MAN_WIDTH:1];                 // dropped LSB = truncation
      exp_n = XW'(e2_q) + 1'b1;
    end else begin
      man_n = shl[MAN_WIDTH-1:0];
      exp_n = XW'(e2_q) - XW'(lz);
    end

    // After the shift the hidden bit is set unless the sum was exactly zero.
    is_zero = (!carry && !shl[MAN_WIDTH]) || exp_n[XW-1] || (exp_n == '0);
    is_ovf  = !is_zero && (exp_n[XW-2:0] >= {1'b0, {EXP_WIDTH{1'b1}}});

    res_d = '0;
    nan_d = 1'b0;
    inf_d = 1'b0;
    ovf_d = 1'b0;
    if (nan2_q) begin
      res_d = {1'b0, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b1}}};
      nan_d = 1'b1;
    end else if (inf2_q) begin
      res_d = {isgn2_q, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
      inf_d = 1'b1;
    end else if (is_zero) begin
      res_d = '0;
    end else if (is_ovf) begin
      res_d = {sgn3, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
      inf_d = 1'b1;
      ovf_d = 1'b1;
    end else begin
      res_d = {sgn3, exp_n[EXP_WIDTH-1:0], man_n};
    end
  end

  logic [FLOAT_WIDTH-1:0] res_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic                   nan_q, inf_q, ovf_q;

  // Control and output registers; output fields clear on bubbles so the
  // flags are 0 whenever out_valid is 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      res_q <= '0;
      tag_q <= '0;
      nan_q <= 1'b0;
      inf_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (ld1) v1_q <= in_valid;
      if (ld2) v2_q <= v1_q;
      if (ld3) begin
        v3_q  <= v2_q;
        res_q <= v2_q ? res_d  : '0;
        tag_q <= v2_q ? tag2_q : '0;
        nan_q <= v2_q && nan_d;
        inf_q <= v2_q && inf_d;
        ovf_q <= v2_q && ovf_d;
      end
    end
  end

  // Internal datapath registers carry no reset; their valids qualify them.
  always_ff @(posedge clk) begin
    if (ld1) begin
      a1_q    <= b_sm;
      b1_q    <= s_al;
      e1_q    <= b_exp;
      nan1_q  <= nan1_d;
      inf1_q  <= inf1_d;
      isgn1_q <= b_sgn;
      tag1_q  <= in_tag;
    end
    if (ld2) begin
      sum2_q  <= a1_q + b1_q;
      e2_q    <= e1_q;
      nan2_q  <= nan1_q;
      inf2_q  <= inf1_q;
      isgn2_q <= isgn1_q;
      tag2_q  <= tag1_q;
    end
  end

  assign out_valid = v3_q;
  assign res       = res_q;
  assign out_tag   = tag_q;
  assign flag_nan  = nan_q;
  assign flag_inf  = inf_q;
  assign flag_ovf  = ovf_q;

endmodule

// File: tb/tb_float_add_pipe.sv
// tb/tb_float_add_pipe.sv - directed self-checking bench for float_add_pipe
module tb_float_add_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] lhs, rhs;
  logic        op_sub;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic [3:0]  out_tag;
  logic        flag_nan, flag_inf, flag_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  float_add_pipe #(.EXP_WIDTH(8), .MAN_WIDTH(23), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .lhs(lhs), .rhs(rhs), .op_sub(op_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .out_tag(out_tag),
    .flag_nan(flag_nan), .flag_inf(flag_inf), .flag_ovf(flag_ovf)
  );

  // Drives one transaction with out_ready=1 and returns what emerges, plus
  // the number of rising edges from the accept edge (counted as 1) to out_valid.
  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [3:0] tag, output logic [31:0] r, output logic [3:0] t,
                          output logic [2:0] fl, output int lat);
    int n;
    @(posedge clk); #1;
    lhs = a; rhs = b; op_sub = sub; in_tag = tag; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    r = res; t = out_tag; fl = {flag_nan, flag_inf, flag_ovf};
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    lhs = '0; rhs = '0; op_sub = 1'b0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, res, out_tag, flag_nan, flag_inf, flag_ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b rdy=%b res=%h tag=%h flags=%b%b%b, expected all zero",
               out_valid, in_ready, res, out_tag, flag_nan, flag_inf, flag_ovf);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] r; logic [3:0] t; logic [2:0] fl; int lat;
    send_one(32'h3F800000, 32'h3F800000, 1'b0, 4'd5, r, t, fl, lat);
    checks++;
    if (r !== 32'h40000000) begin
      errors++; $display("FAIL basic_res: got %h expected 40000000", r);
    end
    checks++;
    if (t !== 4'd5) begin
      errors++; $display("FAIL basic_tag: got %0d expected 5", t);
    end
    checks++;
    if (lat !== 3) begin
      errors++; $display("FAIL basic_latency: got %0d expected 3", lat);
    end
    checks++;
    if (fl !== 3'b000) begin
      errors++; $display("FAIL basic_flags: got %b expected 000", fl);
    end
  endtask

  task automatic test_arith();
    logic [31:0] va [0:7] = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h3FC00000,
                              32'h00400000, 32'h00800000, 32'h4B800000, 32'hC0000000};
    logic [31:0] vb [0:7] = '{32'h3F800000, 32'hBF800000, 32'h40400000, 32'h3F800000,
                              32'h3F800000, 32'h00C00000, 32'h3F800000, 32'h3F800000};
    logic        vs [0:7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ve [0:7] = '{32'h00000000, 32'h40000000, 32'hC0000000, 32'h3F000000,
                              32'h3F800000, 32'h00000000, 32'h4B800000, 32'hBF800000};
    logic [31:0] r; logic [3:0] t; logic [2:0] fl; int lat;
    for (int i = 0; i < 8; i++) begin
      send_one(va[i], vb[i], vs[i], 4'(i + 8), r, t, fl, lat);
      checks++;
      if (r !== ve[i] || t !== 4'(i + 8) || fl !== 3'b000) begin
        errors++;
        $display("FAIL arith_%0d: got res=%h tag=%0d flags=%b expected res=%h tag=%0d flags=000",
                 i, r, t, fl, ve[i], i + 8);
      end
    end
  endtask

  task automatic test_specials();
    logic [31:0] va [0:5] = '{32'h7F800000, 32'h7F7FFFFF, 32'h3F800000,
                              32'h7FC00000, 32'h7F800000, 32'hFF7FFFFF};
    logic [31:0] vb [0:5] = '{32'hFF800000, 32'h7F7FFFFF, 32'hFF800000,
                              32'h3F800000, 32'h7F800000, 32'h7F7FFFFF};
    logic        vs [0:5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] ve [0:5] = '{32'h7FFFFFFF, 32'h7F800000, 32'hFF800000,
                              32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFF800000};
    logic [2:0]  vf [0:5] = '{3'b100, 3'b011, 3'b010, 3'b100, 3'b100, 3'b011};
    logic [31:0] r; logic [3:0] t; logic [2:0] fl; int lat;
    for (int i = 0; i < 6; i++) begin
      send_one(va[i], vb[i], vs[i], 4'(i + 1), r, t, fl, lat);
      checks++;
      if (r !== ve[i] || fl !== vf[i]) begin
        errors++;
        $display("FAIL special_%0d: got res=%h flags(nan,inf,ovf)=%b expected res=%h flags=%b",
                 i, r, fl, ve[i], vf[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic saw_stall;
    logic stable_ok;
    saw_stall = 1'b0;
    stable_ok = 1'b1;
    out_ready = 1'b1;
    fork
      begin
        int n;
        @(posedge clk); #1;
        for (int k = 1; k <= 4; k++) begin
          lhs = 32'h3F800000; rhs = 32'h3F800000; op_sub = 1'b0;
          in_tag = 4'(k); in_valid = 1'b1;
          n = 0;
          @(negedge clk); #1;
          while (!in_ready && n < 50) begin
            saw_stall = 1'b1;
            @(negedge clk); #1;
            n++;
          end
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'd1) begin
          errors++;
          $display("FAIL b2b_first: got v=%b tag=%0d expected v=1 tag=1", out_valid, out_tag);
        end
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (out_valid !== 1'b1 || out_tag !== 4'd1 || res !== 32'h40000000 ||
              {flag_nan, flag_inf, flag_ovf} !== 3'b000)
            stable_ok = 1'b0;
        end
        checks++;
        if (stable_ok !== 1'b1) begin
          errors++;
          $display("FAIL b2b_hold: got unstable output during stall, expected tag 1 res 40000000 held");
        end
        out_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
          @(negedge clk);
          checks++;
          if (out_valid !== 1'b1 || out_tag !== 4'(k) || res !== 32'h40000000) begin
            errors++;
            $display("FAIL b2b_order_%0d: got v=%b tag=%0d res=%h expected v=1 tag=%0d res=40000000",
                     k, out_valid, out_tag, res, k);
          end
        end
      end
    join
    checks++;
    if (saw_stall !== 1'b1) begin
      errors++; $display("FAIL b2b_in_ready_drop: got %b expected 1", saw_stall);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_no_dup: got out_valid %b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    logic [31:0] r; logic [3:0] t; logic [2:0] fl; int lat;
    out_ready = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k <= 3; k++) begin
      lhs = 32'h40400000; rhs = 32'h3F800000; op_sub = 1'b0;
      in_tag = 4'(k); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_ready_in_reset: got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || res !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_after: got rdy=%b v=%b res=%h expected rdy=1 v=0 res=00000000",
               in_ready, out_valid, res);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL rstmid_discard: got %0d valid cycles expected 0", seen);
    end
    send_one(32'h40400000, 32'h3F800000, 1'b0, 4'd9, r, t, fl, lat);
    checks++;
    if (r !== 32'h40800000 || t !== 4'd9 || lat !== 3) begin
      errors++;
      $display("FAIL rstmid_recover: got res=%h tag=%0d lat=%0d expected res=40800000 tag=9 lat=3",
               r, t, lat);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_specials();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
